ifid_pipe_ctrl: RTL and testbench

Hazard and sequencing controller for the IF/ID pipeline register of the WISC-S15 16-bit pipeline. It replaces the free-running enable counter with a state machine that decides every cycle whether the PC and IF/ID register load, hold, or are flushed to a NOP. It also decides whether a bubble is injected into ID/EX. It sits beside IF/ID and consumes the decoded ID fields plus EX-stage load/branch status and the instruction-memory valid signal.

---
 rtl/wisc_pkg.sv | 23 ++
 rtl/ifid_pipe_ctrl_if.sv | 46 ++++
 rtl/ifid_hazard_detect.sv | 14 +
 rtl/ifid_pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ifid_pipe_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC-S15 definitions: opcode encodings, the NOP instruction word
// and the IF/ID sequencing controller state encoding.
package wisc_pkg;

    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Instruction word loaded into IF/ID when it is flushed.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_RUN       = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_IMEM_WAIT = 3'd3,
        ST_HALT      = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/ifid_pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the IF/ID
// sequencing controller (slave). Defining IFID_PIPE_CTRL_PERF_EN adds the
// stall/flush performance counters to the bundle.
interface ifid_pipe_ctrl_if;

    logic       imem_valid;
    logic [3:0] id_opcode;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       ex_mem_read;
    logic [3:0] ex_rd;
    logic       ex_branch_taken;

    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       halted;
    logic [2:0] state;

`ifdef IFID_PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output imem_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, halted, state, stall_cnt, flush_cnt
    );
`else
    modport master (
        output imem_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, halted, state
    );

    modport slave (
        input  imem_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, halted, state
    );
`endif

endinterface

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands in ID.
// Purely combinational so the forwarding unit can reuse it.
module ifid_hazard_detect (
    input  logic       mem_read_i,
    input  logic [3:0] rd_i,
    input  logic [3:0] rs_i,
    input  logic [3:0] rt_i,
    output logic       lu_o
);

    // R0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign lu_o = mem_read_i && (rd_i != 4'd0) && ((rd_i == rs_i) || (rd_i == rt_i));

endmodule

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID hazard and sequencing controller for the WISC-S15 pipeline.
// Decides each cycle whether PC and IF/ID load, hold or flush, and whether a
// bubble enters ID/EX. Outputs are Mealy (state plus current inputs).
// Optional macro IFID_PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module ifid_pipe_ctrl
    import wisc_pkg::*;
#(
    // Fetches squashed after a taken branch, including the branch cycle; 1..7.
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    ifid_pipe_ctrl_if.slave  bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        lu;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, halted;

    ifid_hazard_detect u_hazard (
        .mem_read_i (bus.ex_mem_read),
        .rd_i       (bus.ex_rd),
        .rs_i       (bus.id_rs),
        .rt_i       (bus.id_rt),
        .lu_o       (lu)
    );

    // State and flush counter registers; reset discards any pending flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= 3'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Mealy output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_FILL: begin
                pc_we       = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_RUN;
            end

            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    pc_we       = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (lu) begin
                    // Hold PC and IF/ID; the load leaves EX next cycle.
                    idex_bubble = 1'b1;
                end else if (!bus.imem_valid) begin
                    state_d = ST_IMEM_WAIT;
                end else if (bus.id_opcode == OP_HLT) begin
                    idex_bubble = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Only bubbles are in EX here, so a branch cannot be taken.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pc_we       = bus.imem_valid;
                if (bus.imem_valid) begin
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            ST_IMEM_WAIT: begin
                if (bus.ex_branch_taken) begin
                    pc_we       = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (bus.imem_valid) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    idex_bubble = 1'b1;
                end
            end

            ST_HALT: begin
                halted      = 1'b1;
                idex_bubble = 1'b1;
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.halted      = halted;
    assign bus.state       = state_q;

`ifdef IFID_PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters of frozen-PC cycles and flushed-fetch cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_we && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ifid_flush && (state_q != ST_FILL) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed self-checking bench for ifid_pipe_ctrl with FLUSH_CYCLES=2.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_ifid_pipe_ctrl;

    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       mem_read;
        logic [3:0] rd;
        logic       br;
    } stim_t;

    // Output vector: {pc_we, ifid_we, ifid_flush, idex_bubble, halted, state[2:0]}
    localparam logic [7:0] V_FILL        = 8'b1011_0000;
    localparam logic [7:0] V_RUN         = 8'b1100_0001;
    localparam logic [7:0] V_LU          = 8'b0001_0001;
    localparam logic [7:0] V_HLT_RUN     = 8'b0001_0001;
    localparam logic [7:0] V_BR_RUN      = 8'b1011_0001;
    localparam logic [7:0] V_MISS_RUN    = 8'b0000_0001;
    localparam logic [7:0] V_FLUSH_V     = 8'b1011_0010;
    localparam logic [7:0] V_FLUSH_NV    = 8'b0011_0010;
    localparam logic [7:0] V_WAIT        = 8'b0001_0011;
    localparam logic [7:0] V_WAIT_RESUME = 8'b1100_0011;
    localparam logic [7:0] V_BR_WAIT     = 8'b1011_0011;
    localparam logic [7:0] V_HALT        = 8'b0001_1100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ifid_pipe_ctrl_if bus ();

    ifid_pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [7:0] obs = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
                      bus.halted, bus.state};

    function automatic stim_t mk(input logic v, input logic [3:0] op, input logic [3:0] rs,
                                 input logic [3:0] rt, input logic mr, input logic [3:0] rd,
                                 input logic br);
        stim_t s;
        s.valid = v; s.opcode = op; s.rs = rs; s.rt = rt;
        s.mem_read = mr; s.rd = rd; s.br = br;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.imem_valid      = s.valid;
        bus.id_opcode       = s.opcode;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.ex_mem_read     = s.mem_read;
        bus.ex_rd           = s.rd;
        bus.ex_branch_taken = s.br;
    endtask

    task automatic test_reset;
        drive(mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0));
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (obs !== V_FILL) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, V_FILL);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== V_FILL) begin
            n_fail++;
            $display("FAIL reset_cycle0: got %b expected %b", obs, V_FILL);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== V_RUN) begin
            n_fail++;
            $display("FAIL reset_cycle1: got %b expected %b", obs, V_RUN);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use;
        stim_t      st[9];
        logic [7:0] ex[9];
        st[0] = mk(1, 4'h0, 4'd3, 4'd2, 1, 4'd3, 0); ex[0] = V_LU;
        st[1] = mk(1, 4'h0, 4'd3, 4'd2, 0, 4'd0, 0); ex[1] = V_RUN;
        st[2] = mk(1, 4'h0, 4'd3, 4'd2, 1, 4'd0, 0); ex[2] = V_RUN;
        st[3] = mk(1, 4'h0, 4'd1, 4'd5, 1, 4'd5, 0); ex[3] = V_LU;
        st[4] = mk(1, 4'h0, 4'd3, 4'd2, 0, 4'd3, 0); ex[4] = V_RUN;
        st[5] = mk(0, 4'h0, 4'd7, 4'd2, 1, 4'd7, 0); ex[5] = V_LU;
        st[6] = mk(0, 4'h0, 4'd7, 4'd2, 0, 4'd0, 0); ex[6] = V_MISS_RUN;
        st[7] = mk(1, 4'h0, 4'd7, 4'd2, 0, 4'd0, 0); ex[7] = V_WAIT_RESUME;
        st[8] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[8] = V_RUN;
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_imem_wait;
        stim_t      st[5];
        logic [7:0] ex[5];
        st[0] = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[0] = V_MISS_RUN;
        st[1] = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[1] = V_WAIT;
        st[2] = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[2] = V_WAIT;
        st[3] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[3] = V_WAIT_RESUME;
        st[4] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[4] = V_RUN;
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL imem_wait[%0d]: got %b expected %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        stim_t      st[15];
        logic [7:0] ex[15];
        // Plain taken branch: branch cycle plus one flush cycle.
        st[0]  = mk(1, 4'hC, 4'd1, 4'd2, 0, 4'd0, 1); ex[0]  = V_BR_RUN;
        st[1]  = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[1]  = V_FLUSH_V;
        st[2]  = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[2]  = V_RUN;
        // imem_valid low in FLUSH holds the count; a branch there is ignored.
        st[3]  = mk(1, 4'hD, 4'd1, 4'd2, 0, 4'd0, 1); ex[3]  = V_BR_RUN;
        st[4]  = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[4]  = V_FLUSH_NV;
        st[5]  = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[5]  = V_FLUSH_NV;
        st[6]  = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 1); ex[6]  = V_FLUSH_V;
        st[7]  = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[7]  = V_RUN;
        // Branch resolving while waiting on instruction memory.
        st[8]  = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[8]  = V_MISS_RUN;
        st[9]  = mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 1); ex[9]  = V_BR_WAIT;
        st[10] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[10] = V_FLUSH_V;
        st[11] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[11] = V_RUN;
        // Branch wins over a simultaneous load-use hazard.
        st[12] = mk(1, 4'hE, 4'd3, 4'd2, 1, 4'd3, 1); ex[12] = V_BR_RUN;
        st[13] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[13] = V_FLUSH_V;
        st[14] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0); ex[14] = V_RUN;
        for (int i = 0; i < 15; i++) begin
            drive(st[i]);
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_flush;
        drive(mk(1, 4'hC, 4'd1, 4'd2, 0, 4'd0, 1));
        #1;
        n_checks++;
        if (obs !== V_BR_RUN) begin
            n_fail++;
            $display("FAIL rst_flush_branch: got %b expected %b", obs, V_BR_RUN);
        end
        @(negedge clk);
        drive(mk(0, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0));
        #1;
        n_checks++;
        if (obs !== V_FLUSH_NV) begin
            n_fail++;
            $display("FAIL rst_flush_in_flush: got %b expected %b", obs, V_FLUSH_NV);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_FILL) begin
            n_fail++;
            $display("FAIL rst_flush_async: got %b expected %b", obs, V_FILL);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0));
        #1;
        n_checks++;
        if (obs !== V_FILL) begin
            n_fail++;
            $display("FAIL rst_flush_fill: got %b expected %b", obs, V_FILL);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== V_RUN) begin
            n_fail++;
            $display("FAIL rst_flush_run: got %b expected %b", obs, V_RUN);
        end
        @(negedge clk);
    endtask

`ifdef IFID_PIPE_CTRL_PERF_EN
    task automatic test_perf_counters;
        stim_t st[7];
        rst = 1'b1;
        drive(mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0));
        @(negedge clk);
        rst = 1'b0;
        st[0] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0);
        st[1] = mk(1, 4'h0, 4'd3, 4'd2, 1, 4'd3, 0);
        st[2] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0);
        st[3] = mk(1, 4'h0, 4'd1, 4'd4, 1, 4'd4, 0);
        st[4] = mk(1, 4'hC, 4'd1, 4'd2, 0, 4'd0, 1);
        st[5] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0);
        st[6] = mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bus.stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_stall_cnt: got %0d expected 2", bus.stall_cnt);
        end
        n_checks++;
        if (bus.flush_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_flush_cnt: got %0d expected 2", bus.flush_cnt);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_halt;
        drive(mk(1, 4'hF, 4'd1, 4'd2, 0, 4'd0, 0));
        #1;
        n_checks++;
        if (obs !== V_HLT_RUN) begin
            n_fail++;
            $display("FAIL halt_enter: got %b expected %b", obs, V_HLT_RUN);
        end
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            drive(mk(logic'(i % 3 != 0), 4'hF, 4'd3, 4'd2, logic'(i % 5 == 0), 4'd3,
                     logic'(i % 7 == 0)));
            #1;
            n_checks++;
            if (obs !== V_HALT) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %b expected %b", i, obs, V_HALT);
            end
            @(negedge clk);
        end
        drive(mk(1, 4'h0, 4'd1, 4'd2, 0, 4'd0, 0));
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_FILL) begin
            n_fail++;
            $display("FAIL halt_async_rst: got %b expected %b", obs, V_FILL);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== V_FILL) begin
            n_fail++;
            $display("FAIL halt_release_fill: got %b expected %b", obs, V_FILL);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== V_RUN) begin
            n_fail++;
            $display("FAIL halt_release_run: got %b expected %b", obs, V_RUN);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_imem_wait();
        test_branch();
        test_reset_mid_flush();
`ifdef IFID_PIPE_CTRL_PERF_EN
        test_perf_counters();
`endif
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
